// File: rtl/ysyx_22051013_wb_arbiter.sv
// Write-back arbiter for the integer register file.
// Merges ALU (no backpressure), MDU and LSU (valid/ready) results onto a single
// registered write port. ALU has fixed priority; MDU/LSU share round-robin.
// A starve counter raises alu_hold so a pending MDU/LSU result cannot be
// locked out indefinitely by back-to-back ALU results.
// Optional macro YSYX_22051013_WB_PERF_EN adds the wb_cnt write-cycle counter.
module ysyx_22051013_wb_arbiter #(
  parameter int unsigned ADDR_W       = 5,
  parameter int unsigned DATA_W       = 64,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_waddr,
  input  logic [DATA_W-1:0] alu_wdata,
  output logic              alu_hold,
  input  logic              mdu_valid,
  output logic              mdu_ready,
  input  logic [ADDR_W-1:0] mdu_waddr,
  input  logic [DATA_W-1:0] mdu_wdata,
  input  logic              lsu_valid,
  output logic              lsu_ready,
  input  logic [ADDR_W-1:0] lsu_waddr,
  input  logic [DATA_W-1:0] lsu_wdata,
  output logic              wen,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata
`ifdef YSYX_22051013_WB_PERF_EN
  ,
  output logic [63:0]       wb_cnt
`endif
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned PERF_W = 64;
  localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(STARVE_LIMIT - 1);

  logic              ptr_mdu;     // 1: MDU wins a tie, 0: LSU wins a tie
  logic [CNT_W-1:0]  starve_cnt;
  logic              grant_mdu;
  logic              grant_lsu;
  logic              grant_bp;
  logic              pending;
  logic              sel_valid;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  // Grant decision: ALU first, flush blocks MDU/LSU, round-robin on a tie
  always_comb begin
    grant_mdu = 1'b0;
    grant_lsu = 1'b0;
    if (!alu_valid && !flush) begin
      if (mdu_valid && (!lsu_valid || ptr_mdu)) begin
        grant_mdu = 1'b1;
      end else if (lsu_valid) begin
        grant_lsu = 1'b1;
      end
    end
  end

  assign grant_bp  = grant_mdu | grant_lsu;
  assign pending   = mdu_valid | lsu_valid;
  assign mdu_ready = grant_mdu & rst;
  assign lsu_ready = grant_lsu & rst;

  // Select the payload of whichever source won this cycle
  always_comb begin
    sel_valid = 1'b0;
    sel_addr  = '0;
    sel_data  = '0;
    if (alu_valid) begin
      sel_valid = 1'b1;
      sel_addr  = alu_waddr;
      sel_data  = alu_wdata;
    end else if (grant_mdu) begin
      sel_valid = 1'b1;
      sel_addr  = mdu_waddr;
      sel_data  = mdu_wdata;
    end else if (grant_lsu) begin
      sel_valid = 1'b1;
      sel_addr  = lsu_waddr;
      sel_data  = lsu_wdata;
    end
  end

  // Registered write port, round-robin pointer and anti-starvation state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wen        <= 1'b0;
      waddr      <= '0;
      wdata      <= '0;
      ptr_mdu    <= 1'b1;
      starve_cnt <= '0;
      alu_hold   <= 1'b0;
    end else begin
      // writes to x0 are consumed but never reach the register file
      wen <= sel_valid && (sel_addr != '0);
      if (sel_valid) begin
        waddr <= sel_addr;
        wdata <= sel_data;
      end
      if (grant_bp) begin
        ptr_mdu <= grant_lsu;
      end
      if (grant_bp || !pending) begin
        starve_cnt <= '0;
        alu_hold   <= 1'b0;
      end else begin
        if (starve_cnt < LIMIT) begin
          starve_cnt <= starve_cnt + CNT_W'(1);
        end
        if (starve_cnt >= LIMIT_M1) begin
          alu_hold <= 1'b1;
        end
      end
    end
  end

`ifdef YSYX_22051013_WB_PERF_EN
  // Count cycles in which the register file is written
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_cnt <= '0;
    end else begin
      wb_cnt <= wb_cnt + PERF_W'(wen);
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_22051013_wb_arbiter.sv
// Randomized scoreboard bench for ysyx_22051013_wb_arbiter.
module tb_ysyx_22051013_wb_arbiter;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 64;
  localparam int LIMIT = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              flush = 1'b0;
  logic              alu_valid = 1'b0;
  logic [ADDR_W-1:0] alu_waddr = '0;
  logic [DATA_W-1:0] alu_wdata = '0;
  logic              alu_hold;
  logic              mdu_valid = 1'b0;
  logic              mdu_ready;
  logic [ADDR_W-1:0] mdu_waddr = '0;
  logic [DATA_W-1:0] mdu_wdata = '0;
  logic              lsu_valid = 1'b0;
  logic              lsu_ready;
  logic [ADDR_W-1:0] lsu_waddr = '0;
  logic [DATA_W-1:0] lsu_wdata = '0;
  logic              wen;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
`ifdef YSYX_22051013_WB_PERF_EN
  logic [63:0]       wb_cnt;
`endif

  ysyx_22051013_wb_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .alu_valid(alu_valid), .alu_waddr(alu_waddr), .alu_wdata(alu_wdata),
    .alu_hold(alu_hold),
    .mdu_valid(mdu_valid), .mdu_ready(mdu_ready),
    .mdu_waddr(mdu_waddr), .mdu_wdata(mdu_wdata),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready),
    .lsu_waddr(lsu_waddr), .lsu_wdata(lsu_wdata),
    .wen(wen), .waddr(waddr), .wdata(wdata)
`ifdef YSYX_22051013_WB_PERF_EN
    , .wb_cnt(wb_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              wen;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              hold;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_fail = 0;

  // reference model state
  bit              pref_mdu = 1'b1;
  int              streak = 0;
  bit              hold_m = 1'b0;
  longint unsigned perf_exp = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // One cycle of stimulus: drive, check readies against the model, queue the write
  task automatic step(input bit av, input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] ad,
                      input bit mv, input logic [ADDR_W-1:0] ma, input logic [DATA_W-1:0] md,
                      input bit lv, input logic [ADDR_W-1:0] la, input logic [DATA_W-1:0] ld,
                      input bit fl, output bit gm, output bit gl);
    exp_t e;
    @(negedge clk);
    alu_valid = av; alu_waddr = aa; alu_wdata = ad;
    mdu_valid = mv; mdu_waddr = ma; mdu_wdata = md;
    lsu_valid = lv; lsu_waddr = la; lsu_wdata = ld;
    flush = fl;
    #1;
    gm = 1'b0;
    gl = 1'b0;
    if (!av && !fl) begin
      if (mv && lv) begin
        gm = pref_mdu;
        gl = !pref_mdu;
      end else begin
        gm = mv;
        gl = lv;
      end
    end
    chk("mdu_ready", 64'(mdu_ready), 64'(gm));
    chk("lsu_ready", 64'(lsu_ready), 64'(gl));
    e.wen = 1'b0; e.addr = '0; e.data = '0;
    if (av) begin
      e.wen = (aa != 0); e.addr = aa; e.data = ad;
    end else if (gm) begin
      e.wen = (ma != 0); e.addr = ma; e.data = md;
    end else if (gl) begin
      e.wen = (la != 0); e.addr = la; e.data = ld;
    end
    if (gm || gl) begin
      pref_mdu = gl;
      streak = 0;
      hold_m = 1'b0;
    end else if (!(mv || lv)) begin
      streak = 0;
      hold_m = 1'b0;
    end else begin
      streak++;
      hold_m = (streak >= LIMIT);
    end
    e.hold = hold_m;
    q.push_back(e);
  endtask

  task automatic idle();
    bit gm, gl;
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, gm, gl);
  endtask

  task automatic model_reset();
    q.delete();
    pref_mdu = 1'b1;
    streak = 0;
    hold_m = 1'b0;
    perf_exp = 0;
  endtask

  // Hold reset for a few cycles with requests present; check reset state
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    alu_valid = 1'b0; flush = 1'b0;
    mdu_valid = 1'b1; lsu_valid = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_mdu_ready", 64'(mdu_ready), 64'd0);
    chk("rst_lsu_ready", 64'(lsu_ready), 64'd0);
    chk("rst_wen", 64'(wen), 64'd0);
    chk("rst_waddr", 64'(waddr), 64'd0);
    chk("rst_wdata", wdata, 64'd0);
    chk("rst_alu_hold", 64'(alu_hold), 64'd0);
    mdu_valid = 1'b0; lsu_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Monitor: pop one expectation per cycle after each active edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst && q.size() > 0) begin
        e = q.pop_front();
        chk("wen", 64'(wen), 64'(e.wen));
        chk("alu_hold", 64'(alu_hold), 64'(e.hold));
        if (e.wen) begin
          chk("waddr", 64'(waddr), 64'(e.addr));
          chk("wdata", wdata, e.data);
        end
`ifdef YSYX_22051013_WB_PERF_EN
        chk("wb_cnt", wb_cnt, perf_exp);
`endif
        perf_exp += 64'(e.wen);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit gm, gl;
    bit mp, lp;
    logic [ADDR_W-1:0] ma_r, la_r;
    logic [DATA_W-1:0] md_r, ld_r;
    bit av, fl;

    do_reset();

    // single ALU write then idle
    step(1, 5, 64'h1234, 0, 0, 0, 0, 0, 0, 0, gm, gl);
    idle();
    idle();

    // both backpressured sources valid: MDU first, then LSU
    step(0, 0, 0, 1, 3, 64'hA0A0, 1, 4, 64'hB0B0, 0, gm, gl);
    chk("rr_first_mdu", 64'(mdu_ready), 64'd1);
    step(0, 0, 0, 1, 3, 64'hA1A1, 1, 4, 64'hB0B0, 0, gm, gl);
    chk("rr_second_lsu", 64'(lsu_ready), 64'd1);
    step(0, 0, 0, 1, 3, 64'hA1A1, 0, 0, 0, 0, gm, gl);
    idle();

    // starvation: ALU continuously wins over a pending MDU
    do_reset();
    for (int i = 0; i < 9; i++) begin
      step(1, ADDR_W'(i + 1), 64'(i * 16 + 7), 1, 9, 64'hD00D, 0, 0, 0, 0, gm, gl);
      if (i == 7) chk("alu_hold_c7", 64'(alu_hold), 64'd0);
      if (i == 8) chk("alu_hold_c8", 64'(alu_hold), 64'd1);
    end
    step(0, 0, 0, 1, 9, 64'hD00D, 0, 0, 0, 0, gm, gl);
    chk("starve_grant_c9", 64'(mdu_ready), 64'd1);
    idle();
    chk("alu_hold_c10", 64'(alu_hold), 64'd0);
    idle();

    // x0 write from LSU is consumed without a register write
    step(0, 0, 0, 0, 0, 0, 1, 0, 64'hFF, 0, gm, gl);
    chk("x0_lsu_ready", 64'(lsu_ready), 64'd1);
    idle();

    // flush blocks MDU for two cycles
    step(0, 0, 0, 1, 12, 64'hCAFE, 0, 0, 0, 1, gm, gl);
    step(0, 0, 0, 1, 12, 64'hCAFE, 0, 0, 0, 1, gm, gl);
    step(0, 0, 0, 1, 12, 64'hCAFE, 0, 0, 0, 0, gm, gl);
    chk("flush_grant_c3", 64'(mdu_ready), 64'd1);
    idle();
    idle();

    // randomized traffic, two ALU densities
    mp = 0; lp = 0;
    ma_r = '0; la_r = '0; md_r = '0; ld_r = '0;
    for (int ph = 0; ph < 2; ph++) begin
      for (int n = 0; n < 400; n++) begin
        if (!mp && ($urandom % 3 == 0)) begin
          mp = 1; ma_r = ADDR_W'($urandom_range(0, 31)); md_r = {$urandom, $urandom};
        end
        if (!lp && ($urandom % 3 == 0)) begin
          lp = 1; la_r = ADDR_W'($urandom_range(0, 31)); ld_r = {$urandom, $urandom};
        end
        av = (ph == 0) ? ($urandom % 2 == 0) : ($urandom % 10 != 0);
        av = av && !hold_m;
        fl = ($urandom % 10 == 0);
        step(av, ADDR_W'($urandom_range(0, 31)), {$urandom, $urandom},
             mp, ma_r, md_r, lp, la_r, ld_r, fl, gm, gl);
        if (gm) mp = 0;
        if (gl) lp = 0;
      end
    end
    while (mp || lp) begin
      step(0, 0, 0, mp, ma_r, md_r, lp, la_r, ld_r, 0, gm, gl);
      if (gm) mp = 0;
      if (gl) lp = 0;
    end
    idle();

    // asynchronous reset while a write and alu_hold are both visible
    do_reset();
    for (int i = 0; i < 9; i++) begin
      step(1, 17, 64'h5555_AAAA, 1, 9, 64'hD00D, 0, 0, 0, 0, gm, gl);
    end
    @(posedge clk);
    #3;
    chk("pre_rst_wen", 64'(wen), 64'd1);
    chk("pre_rst_hold", 64'(alu_hold), 64'd1);
    rst = 1'b0;
    #1;
    chk("async_rst_wen", 64'(wen), 64'd0);
    chk("async_rst_waddr", 64'(waddr), 64'd0);
    chk("async_rst_wdata", wdata, 64'd0);
    chk("async_rst_hold", 64'(alu_hold), 64'd0);
`ifdef YSYX_22051013_WB_PERF_EN
    chk("async_rst_wb_cnt", wb_cnt, 64'd0);
`endif
    do_reset();
    idle();
    idle();
    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", 64'(q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
